result_reader: RTL and testbench
================================

Name: result_reader

Overview:
- Read-back engine for the result SRAM.
- After the ALU/write-back path has stored the 18-bit MU results, this block walks the SRAM addresses sequentially and reads each word.
- Each result is presented on a valid/ready output stream.
- It is the reader counterpart of the write-back unit and sits between sram_wrapper and the chip output / test interface.

Parameters:
- ADDR_W, 8, SRAM address width.
- DATA_W, 18, result width; taken from read_data[DATA_W-1:0].
- NUM_WORDS, 32, words read per run (8 iterations x 4 MU).
- RY_TIMEOUT, 15, maximum wait cycles for ry before the run aborts.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- rd_start  in  1  single-cycle pulse; starts a run; honoured only in IDLE.
- base_addr  in  ADDR_W  first SRAM address; sampled on an accepted rd_start.
- cs_n  out  1  SRAM chip select, active low.
- we_n  out  1  SRAM write enable, active low; this block always drives 1.
- address  out  ADDR_W  SRAM address.
- read_data  in  32  SRAM read data.
- ry  in  1  SRAM ready; read_data is valid in the same cycle ry=1.
- out_data  out  DATA_W  result word.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts; transfer occurs when out_valid & out_ready.
- busy  out  1  high in any state other than IDLE.
- rd_done  out  1  one-cycle pulse after the last word transfers.
- rd_err  out  1  sticky ry-timeout flag; cleared by the next accepted rd_start.

Behaviour:
- Reset (asynchronous, rst=1): state=IDLE; cs_n=1, we_n=1, address=0; out_data=0, out_valid=0; busy=0, rd_done=0, rd_err=0; word and timeout counters = 0.
- All outputs are registered.
- States: IDLE, ISSUE, WAIT, HOLD, DONE.
- IDLE -> ISSUE on rd_start:
  - address<=base_addr; word_cnt<=0; rd_err<=0.
- ISSUE (1 cycle):
  - cs_n<=0, address held; tmo_cnt<=0; -> WAIT.
- WAIT:
  - cs_n=0 and address held stable.
  - ry=1: out_data<=read_data[DATA_W-1:0]; out_valid<=1; cs_n<=1; -> HOLD.
  - ry=0: tmo_cnt++. When tmo_cnt reaches RY_TIMEOUT: rd_err<=1; cs_n<=1; -> IDLE, with no rd_done.
- HOLD:
  - out_valid=1 and out_data stable until the handshake.
  - Handshake with word_cnt<NUM_WORDS-1: out_valid<=0; word_cnt++; address++; -> ISSUE.
  - Handshake with word_cnt==NUM_WORDS-1: out_valid<=0; -> DONE.
- DONE (1 cycle): rd_done=1; -> IDLE.
- Throughput: minimum 3 cycles per word (ISSUE, WAIT with ry in the first cycle, HOLD with out_ready=1).
- Address wraps modulo 2^ADDR_W; base_addr=8'hF0 with 32 words wraps to 0x00..0x0F. No error is raised on wrap.
- rd_start while busy=1 is ignored: no restart, base_addr is not resampled.
- out_ready=1 outside HOLD has no effect. out_valid never drops without a handshake, except on reset.
- ry=1 outside WAIT is ignored.
- Reset mid-run: immediate return to reset values; cs_n=1 asynchronously; the partial run is discarded.
- Read data bits 31:DATA_W are ignored.
- word_cnt width is clog2(NUM_WORDS); tmo_cnt width is clog2(RY_TIMEOUT+1).

Decomposition:
- Shared package contents:
  - state encoding (IDLE=0, ISSUE=1, WAIT=2, HOLD=3, DONE=4);
  - default ADDR_W / DATA_W / NUM_WORDS constants, shared with the write-back unit so the address map and word count match.
- No sub-module is needed; this is a single FSM plus counters.

Test Plan:
- SRAM model preloaded mem[k]=k*3 (0..93); base_addr=0; out_ready=1; ry in the first WAIT cycle.
  - out_data sequence 0,3,...,93.
  - 32 transfers at a 3-cycle spacing.
  - rd_done pulses once, 1 cycle after the last transfer; busy falls with it.
- out_ready toggled pseudo-randomly, and held 0 for 10 cycles on word 5.
  - out_data/out_valid stay stable while stalled.
  - No word is lost or duplicated; cs_n=1 during the stall.
- SRAM ry delayed 4 cycles per read.
  - address and cs_n=0 are held for 5 WAIT cycles; data correct.
  - With ry stuck 0, rd_err=1 after 15 WAIT cycles; IDLE; no rd_done.
- base_addr=8'hF0.
  - Addresses F0..FF then 00..0F.
  - Data matches mem at each address.
- rd_start pulsed again at word 10 -> ignored; run completes with 32 words from the original base.
- rst asserted mid-WAIT at word 7.
  - cs_n=1, out_valid=0, busy=0 immediately.
  - A following rd_start runs a clean full 32-word read.

Source files
------------

// File: rtl/result_reader_pkg.sv
// Shared definitions for the result read-back path: state encoding and the
// default address/data/word-count constants also used by the write-back unit.
package result_reader_pkg;

  localparam int RR_ADDR_W     = 8;
  localparam int RR_DATA_W     = 18;
  localparam int RR_NUM_WORDS  = 32;
  localparam int RR_RY_TIMEOUT = 15;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } rr_state_e;

endpackage

// File: rtl/result_reader.sv
// Walks NUM_WORDS consecutive result-SRAM addresses from base_addr and streams
// each 18-bit result out on a valid/ready port; aborts if ry never arrives.
module result_reader
  import result_reader_pkg::*;
#(
  parameter int ADDR_W     = RR_ADDR_W,
  parameter int DATA_W     = RR_DATA_W,
  parameter int NUM_WORDS  = RR_NUM_WORDS,
  parameter int RY_TIMEOUT = RR_RY_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              cs_n,
  output logic              we_n,
  output logic [ADDR_W-1:0] address,
  input  logic [31:0]       read_data,
  input  logic              ry,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              rd_done,
  output logic              rd_err
);

  // Output stream handshake: a word moves when out_valid & out_ready are both
  // high on a rising clk edge; once raised, out_valid and out_data hold until
  // that transfer (only reset can drop them early).

  localparam int WCNT_W = $clog2(NUM_WORDS);
  localparam int TMO_W  = $clog2(RY_TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(NUM_WORDS - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(RY_TIMEOUT - 1);

  // All FSM state lives in one struct so checkers can bind to ctrl_q.
  typedef struct packed {
    rr_state_e         state;
    logic [WCNT_W-1:0] word_cnt;
    logic [TMO_W-1:0]  tmo_cnt;
  } ctrl_t;

  ctrl_t             ctrl_q, ctrl_d;
  logic              cs_n_d;
  logic [ADDR_W-1:0] address_d;
  logic [DATA_W-1:0] out_data_d;
  logic              out_valid_d;
  logic              busy_d;
  logic              rd_done_d;
  logic              rd_err_d;

  // Result words are narrower than the SRAM bus; the top bits are dropped.
  logic unused_rd_hi;
  assign unused_rd_hi = ^read_data[31:DATA_W];

  assign we_n = 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q    <= '{state: ST_IDLE, word_cnt: '0, tmo_cnt: '0};
      cs_n      <= 1'b1;
      address   <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      rd_done   <= 1'b0;
      rd_err    <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      cs_n      <= cs_n_d;
      address   <= address_d;
      out_data  <= out_data_d;
      out_valid <= out_valid_d;
      busy      <= busy_d;
      rd_done   <= rd_done_d;
      rd_err    <= rd_err_d;
    end
  end

  always_comb begin
    ctrl_d      = ctrl_q;
    cs_n_d      = cs_n;
    address_d   = address;
    out_data_d  = out_data;
    out_valid_d = out_valid;
    rd_done_d   = 1'b0;
    rd_err_d    = rd_err;

    unique case (ctrl_q.state)
      ST_IDLE: begin
        if (rd_start) begin
          ctrl_d.state    = ST_ISSUE;
          ctrl_d.word_cnt = '0;
          address_d       = base_addr;
          rd_err_d        = 1'b0;
        end
      end
      ST_ISSUE: begin
        cs_n_d         = 1'b0;
        ctrl_d.tmo_cnt = '0;
        ctrl_d.state   = ST_WAIT;
      end
      ST_WAIT: begin
        if (ry) begin
          out_data_d   = read_data[DATA_W-1:0];
          out_valid_d  = 1'b1;
          cs_n_d       = 1'b1;
          ctrl_d.state = ST_HOLD;
        end else begin
          ctrl_d.tmo_cnt = ctrl_q.tmo_cnt + TMO_W'(1);
          // Last permitted wait cycle without ry: give up on the whole run.
          if (ctrl_q.tmo_cnt == TMO_LAST) begin
            rd_err_d     = 1'b1;
            cs_n_d       = 1'b1;
            ctrl_d.state = ST_IDLE;
          end
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (ctrl_q.word_cnt == LAST_WORD) begin
            rd_done_d    = 1'b1;
            ctrl_d.state = ST_DONE;
          end else begin
            ctrl_d.word_cnt = ctrl_q.word_cnt + WCNT_W'(1);
            address_d       = address + ADDR_W'(1);
            ctrl_d.state    = ST_ISSUE;
          end
        end
      end
      ST_DONE: begin
        ctrl_d.state = ST_IDLE;
      end
      default: begin
        ctrl_d.state = ST_IDLE;
        cs_n_d       = 1'b1;
        out_valid_d  = 1'b0;
      end
    endcase

    busy_d = (ctrl_d.state != ST_IDLE);
  end

endmodule

// File: tb/tb_result_reader.sv
// Bench for result_reader: SRAM model with programmable ry latency, a queue of
// expected words/addresses per run, and directed plus randomized runs.
module tb_result_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rd_start = 1'b0;
  logic [7:0]  base_addr = '0;
  logic        cs_n, we_n;
  logic [7:0]  address;
  logic [31:0] read_data;
  logic        ry;
  logic [17:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        busy, rd_done, rd_err;

  result_reader dut (
    .clk(clk), .rst(rst), .rd_start(rd_start), .base_addr(base_addr),
    .cs_n(cs_n), .we_n(we_n), .address(address), .read_data(read_data),
    .ry(ry), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .rd_done(rd_done), .rd_err(rd_err)
  );

  always #5 clk = ~clk;

  int cmp_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- SRAM model ----------------
  logic [31:0] mem [256];
  int          wcnt = 0;
  logic [3:0]  fix_delay = '0;
  logic [3:0]  rnd_delay = '0;
  logic [3:0]  cur_delay;
  logic        noise_bit = 1'b0;
  bit          rand_mode = 0;
  bit          noise_en = 0;
  bit          ry_stuck = 0;

  always @(posedge clk) begin
    if (cs_n !== 1'b0) begin
      wcnt      <= 0;
      rnd_delay <= 4'($urandom_range(0, 6));
    end else begin
      wcnt <= wcnt + 1;
    end
    noise_bit <= 1'($urandom_range(0, 1));
  end

  assign cur_delay = rand_mode ? rnd_delay : fix_delay;
  assign read_data = mem[address];
  assign ry = (cs_n !== 1'b0) ? (noise_en & noise_bit)
                              : (!ry_stuck && (wcnt == int'(cur_delay)));

  // ---------------- scoreboard / monitor ----------------
  logic [17:0] exp_q[$];
  logic [7:0]  addr_q[$];
  bit          mon_en = 0;
  bit          spacing_chk = 0;
  int          xfer_idx = 0;
  int          last_hs_cyc = 0;
  int          done_cnt = 0;
  int          done_base = 0;
  int          low_cnt = 0;
  bit          prev_valid = 0;
  bit          prev_hs = 0;
  logic [17:0] prev_data = '0;
  int          stall_cnt = 0;
  bit          restarted = 0;

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (cs_n === 1'b0) begin
        low_cnt++;
        check("we_n", we_n, 1);
        if (addr_q.size() == 0) check("cs_unexpected", cs_n, 1);
        else check("addr", address, addr_q[0]);
        if (ry) check("wait_len", low_cnt, 32'(cur_delay) + 1);
      end else begin
        low_cnt = 0;
      end
      if (out_valid) check("cs_in_hold", cs_n, 1);
      if (prev_valid && !prev_hs) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, prev_data);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_word", 32'(exp_q.size()), 1);
        end else begin
          check("data", out_data, exp_q.pop_front());
          void'(addr_q.pop_front());
        end
        if (spacing_chk && xfer_idx > 0) check("spacing", cyc - last_hs_cyc, 3);
        last_hs_cyc = cyc;
        xfer_idx++;
      end
      if (rd_done) done_cnt++;
      prev_valid = out_valid;
      prev_hs    = out_valid && out_ready;
      prev_data  = out_data;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_run(input logic [7:0] b);
    exp_q.delete();
    addr_q.delete();
    xfer_idx   = 0;
    low_cnt    = 0;
    prev_valid = 0;
    prev_hs    = 0;
    stall_cnt  = 0;
    restarted  = 0;
    done_base  = done_cnt;
    for (int i = 0; i < 32; i++) begin
      logic [7:0] a;
      a = b + 8'(i);
      addr_q.push_back(a);
      exp_q.push_back(mem[a][17:0]);
    end
    @(posedge clk); #1;
    rd_start  = 1'b1;
    base_addr = b;
    @(posedge clk); #1;
    rd_start  = 1'b0;
    base_addr = ~b;
    check("start_busy", busy, 1);
    check("start_err_clr", rd_err, 0);
  endtask

  // rdy_mode 0: always ready; 1: random, with a 10-cycle stall on word 5.
  task automatic run_until_done(input int rdy_mode, input bit restart_en);
    int n;
    bit seen;
    n = 0;
    seen = 0;
    while (n < 2000 && !seen) begin
      @(posedge clk); #1;
      rd_start = 1'b0;
      if (restart_en && !restarted && xfer_idx == 10) begin
        rd_start  = 1'b1;
        base_addr = 8'h55;
        restarted = 1;
      end
      if (rdy_mode == 0) begin
        out_ready = 1'b1;
      end else if (xfer_idx == 5 && out_valid && stall_cnt < 10) begin
        out_ready = 1'b0;
        stall_cnt++;
      end else begin
        out_ready = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      if (rd_done) seen = 1;
      n++;
    end
    rd_start = 1'b0;
    check("done_seen", seen, 1);
    check("done_gap", cyc - last_hs_cyc, 1);
    check("busy_in_done", busy, 1);
    check("word_count", xfer_idx, 32);
    check("queue_empty", exp_q.size(), 0);
    @(negedge clk);
    check("done_pulse_end", rd_done, 0);
    check("busy_fall", busy, 0);
    check("done_once", done_cnt, done_base + 1);
  endtask

  task automatic fill_random_mem();
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, lows;
    fill_random_mem();
    for (int k = 0; k < 32; k++) mem[k] = {14'($urandom), 18'(k * 3)};

    // Reset values
    #1 rst = 1'b1;
    @(negedge clk);
    check("rst_cs_n", cs_n, 1);
    check("rst_we_n", we_n, 1);
    check("rst_addr", address, 0);
    check("rst_data", out_data, 0);
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", rd_done, 0);
    check("rst_err", rd_err, 0);
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1;

    // Full-rate run: 0,3,...,93 at 3-cycle spacing
    spacing_chk = 1;
    start_run(8'h00);
    run_until_done(0, 0);
    spacing_chk = 0;

    // Random back-pressure with a long stall on word 5
    start_run(8'h00);
    run_until_done(1, 0);
    check("stall_len", stall_cnt, 10);

    // ry delayed 4 cycles per read
    fix_delay = 4'd4;
    start_run(8'h10);
    run_until_done(0, 0);

    // ry stuck low: abort after 15 WAIT cycles, no rd_done
    ry_stuck = 1;
    start_run(8'h20);
    n = 0;
    lows = 0;
    while (busy && n < 60) begin
      @(negedge clk);
      if (cs_n === 1'b0) lows++;
      n++;
    end
    check("tmo_wait_cycles", lows, 15);
    check("tmo_err", rd_err, 1);
    check("tmo_busy", busy, 0);
    check("tmo_cs_n", cs_n, 1);
    check("tmo_no_done", done_cnt, done_base);
    repeat (3) @(negedge clk);
    check("tmo_err_sticky", rd_err, 1);
    ry_stuck = 0;
    fix_delay = 4'd0;

    // Address wrap from F0; also clears rd_err
    start_run(8'hF0);
    run_until_done(0, 0);
    check("wrap_err", rd_err, 0);

    // rd_start while busy is ignored
    start_run(8'h30);
    run_until_done(1, 1);
    check("restart_pulsed", restarted, 1);

    // Reset mid-WAIT on word 7, then a clean run
    fix_delay = 4'd4;
    start_run(8'h40);
    n = 0;
    while (!(xfer_idx == 7 && cs_n === 1'b0) && n < 1000) begin
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(negedge clk);
      n++;
    end
    check("reached_word7_wait", cs_n, 0);
    #2;
    rst = 1'b1;
    mon_en = 0;
    #1;
    check("mid_rst_cs_n", cs_n, 1);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_addr", address, 0);
    check("mid_rst_done", rd_done, 0);
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1;
    start_run(8'h40);
    run_until_done(0, 0);
    fix_delay = 4'd0;

    // Randomized runs: random contents, base, latency, spurious ry outside WAIT
    rand_mode = 1;
    noise_en  = 1;
    for (int r = 0; r < 3; r++) begin
      fill_random_mem();
      start_run(8'($urandom_range(0, 255)));
      run_until_done(1, 0);
    end
    rand_mode = 0;
    noise_en  = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
